// File: rtl/regbus_arbiter_if.sv
// Requester and register-file signals of the shared peripheral register bus.
// The arbiter takes the slave view; requesters plus register file take master.
interface regbus_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               lock_err;
  logic               bus_we;
  logic [AW-1:0]      bus_addr;
  logic [DW-1:0]      bus_wdata;
  logic [DW-1:0]      bus_rdata;

  modport slave (
    input  req, lock, we, addr, wdata,
    input  bus_rdata,
    output gnt, rvalid, rdata, lock_err,
    output bus_we, bus_addr, bus_wdata
  );

  modport master (
    output req, lock, we, addr, wdata,
    output bus_rdata,
    input  gnt, rvalid, rdata, lock_err,
    input  bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter for the single-ported peripheral register bus,
// with lock support for atomic read-modify-write and a lock timeout.
module regbus_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int LOCK_TO = 16
) (
  input  logic clk,
  input  logic rst_n,
  regbus_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LOCK_TO + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic            lock_err_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic            hit;
  int              idx;

  // Scan starts just after the last winner so every requester rotates to the front.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    hit  = 1'b0;
    idx  = 0;
    if (rst_n) begin
      if (state == LOCKED) begin
        if (bus.req[owner]) begin
          hit  = 1'b1;
          gidx = owner;
        end
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (int'(last) + k) % NREQ;
          if (!hit && bus.req[idx]) begin
            hit  = 1'b1;
            gidx = IW'(idx);
          end
        end
      end
      if (hit) gnt[gidx] = 1'b1;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.bus_we    = |(gnt & bus.we);
  assign bus.bus_addr  = bus.addr[int'(gidx)*AW +: AW];
  assign bus.bus_wdata = bus.wdata[int'(gidx)*DW +: DW];
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.lock_err  = lock_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= IW'(NREQ - 1);
      owner      <= '0;
      cnt        <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      lock_err_q <= 1'b0;
    end else begin
      lock_err_q <= 1'b0;
      rvalid_q   <= '0;
      if (hit) begin
        last <= gidx;
        if (!bus.we[gidx]) begin
          rvalid_q <= gnt;
          rdata_q  <= bus.bus_rdata;
        end
      end
      unique case (state)
        IDLE: begin
          if (hit && bus.lock[gidx]) begin
            state <= LOCKED;
            owner <= gidx;
            cnt   <= '0;
          end
        end
        LOCKED: begin
          if (hit && !bus.lock[owner]) begin
            state <= IDLE;
          end else if (bus.req[owner]) begin
            cnt <= '0;
          end else if (cnt == CW'(LOCK_TO - 1)) begin
            // Owner went quiet too long; release the bus to the others.
            state      <= IDLE;
            lock_err_q <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed and random checks of regbus_arbiter against a behavioural model
// of round-robin arbitration, locking and the register file.
module tb_regbus_arbiter;
  localparam int NREQ    = 2;
  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int LOCK_TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bif ();

  regbus_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_TO(LOCK_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  logic [DW-1:0] regs [16] = '{default: '0};
  assign bif.bus_rdata = regs[bif.bus_addr];
  always @(posedge clk) if (bif.bus_we) regs[bif.bus_addr] <= bif.bus_wdata;

  bit              m_locked;
  int              m_owner;
  int              m_last;
  int              m_cnt;
  logic [NREQ-1:0] m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            m_lerr;
  logic [DW-1:0]   m_mem [16] = '{default: '0};

  int total = 0;
  int bad = 0;
  logic [NREQ-1:0] og;
  logic [NREQ-1:0] orv;
  logic [DW-1:0]   ord;
  logic            ole;
  logic            obwe;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = NREQ - 1;
    m_cnt    = 0;
    m_rvalid = '0;
    m_rdata  = '0;
    m_lerr   = 1'b0;
  endtask

  function automatic int pick();
    if (!rst_n) return -1;
    if (m_locked) return bif.req[m_owner] ? m_owner : -1;
    for (int k = 1; k <= NREQ; k++)
      if (bif.req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    return -1;
  endfunction

  task automatic step();
    int g;
    int ia;
    logic [NREQ-1:0] eg;
    logic [AW-1:0] a;
    @(negedge clk);
    g  = pick();
    ia = (g < 0) ? 0 : g;
    eg = (g < 0) ? '0 : NREQ'(1) << g;
    og   = bif.gnt;
    orv  = bif.rvalid;
    ord  = bif.rdata;
    ole  = bif.lock_err;
    obwe = bif.bus_we;
    chk("gnt", og, eg);
    chk("bus_we", obwe, (g >= 0) ? bif.we[ia] : 1'b0);
    chk("bus_addr", bif.bus_addr, bif.addr[ia*AW +: AW]);
    chk("bus_wdata", bif.bus_wdata, bif.wdata[ia*DW +: DW]);
    chk("rvalid", orv, m_rvalid);
    chk("rdata", ord, m_rdata);
    chk("lock_err", ole, m_lerr);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_lerr   = 1'b0;
      m_rvalid = '0;
      if (g >= 0) begin
        m_last = g;
        a = bif.addr[g*AW +: AW];
        if (bif.we[g]) begin
          m_mem[a] = bif.wdata[g*DW +: DW];
        end else begin
          m_rvalid = eg;
          m_rdata  = m_mem[a];
        end
      end
      if (!m_locked) begin
        if (g >= 0 && bif.lock[g]) begin
          m_locked = 1'b1;
          m_owner  = g;
          m_cnt    = 0;
        end
      end else if (g == m_owner && !bif.lock[g]) begin
        m_locked = 1'b0;
      end else if (bif.req[m_owner]) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == LOCK_TO) begin
          m_locked = 1'b0;
          m_lerr   = 1'b1;
          m_cnt    = 0;
        end
      end
    end
    #1;
  endtask

  initial begin
    int n_g1;
    int n_err;
    logic [NREQ-1:0] prev;
    bif.req   = '0;
    bif.lock  = '0;
    bif.we    = '0;
    bif.addr  = '0;
    bif.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state
    bif.req = 2'b11;
    step();
    chk("rst_gnt", og, 2'b00);
    chk("rst_rvalid", orv, 2'b00);
    rst_n = 1'b1;

    // round robin, both reading
    bif.addr = {4'd2, 4'd1};
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_gnt", og, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("rr_rvalid", orv, prev);
      prev = og;
    end

    // write then read back
    bif.req = 2'b01; bif.we = 2'b01;
    bif.addr = {4'd3, 4'd3}; bif.wdata = {8'h00, 8'hA5};
    step();
    chk("wr_gnt", og, 2'b01);
    chk("wr_bus_we", obwe, 1'b1);
    bif.req = 2'b10; bif.we = 2'b00;
    step();
    chk("rd_gnt", og, 2'b10);
    chk("rd_bus_we", obwe, 1'b0);
    bif.req = 2'b00;
    step();
    chk("rd_rvalid", orv, 2'b10);
    chk("rd_rdata", ord, 8'hA5);

    // locked read-modify-write, req1 waits
    bif.req = 2'b11; bif.lock = 2'b01; bif.we = 2'b00;
    bif.addr = {4'd6, 4'd3};
    step();
    chk("rmw_rd_gnt", og, 2'b01);
    n_g1 = 0;
    bif.we = 2'b01; bif.wdata = {8'h00, 8'hA6};
    for (int i = 0; i < 2; i++) begin
      step();
      if (og[1]) n_g1++;
    end
    bif.lock = 2'b00;
    step();
    chk("rmw_unlock_gnt", og, 2'b01);
    chk("rmw_req1_blocked", n_g1, 0);
    bif.we = 2'b00;
    step();
    chk("rmw_after_gnt", og, 2'b10);

    // lock timeout
    bif.req = 2'b01; bif.lock = 2'b01;
    step();
    chk("to_lock_gnt", og, 2'b01);
    bif.req = 2'b10; bif.lock = 2'b00;
    n_g1 = 0; n_err = 0;
    for (int i = 0; i < LOCK_TO; i++) begin
      step();
      if (og[1]) n_g1++;
      if (ole) n_err++;
    end
    chk("to_wait_gnts", n_g1, 0);
    chk("to_early_err", n_err, 0);
    step();
    chk("to_lock_err", ole, 1'b1);
    chk("to_gnt", og, 2'b10);
    step();
    chk("to_err_once", ole, 1'b0);

    // sole requester, full throughput
    bif.req = 2'b00;
    step();
    bif.req = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b2b_gnt", og, 2'b10);
    end

    // reset mid-lock with pending read
    bif.req = 2'b01; bif.lock = 2'b01;
    step();
    chk("ml_gnt", og, 2'b01);
    rst_n = 1'b0; bif.req = 2'b10;
    step();
    chk("ml_rst_gnt", og, 2'b00);
    step();
    chk("ml_rst_rvalid", orv, 2'b00);
    rst_n = 1'b1; bif.lock = 2'b00;
    step();
    chk("ml_after_gnt", og, 2'b10);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(bif.req[i] && !og[i])) begin
          bif.we[i] = 1'($urandom_range(0, 1));
          bif.addr[i*AW +: AW] = AW'($urandom);
          bif.wdata[i*DW +: DW] = DW'($urandom);
        end
        bif.req[i]  = ($urandom_range(0, 3) != 0);
        bif.lock[i] = ($urandom_range(0, 5) == 0);
      end
      if (c % 50 == 25) bif.req = '0;
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
